// File: rtl/periph_bus_arbiter.sv
// periph_bus_arbiter: round-robin two-master to one-slave arbiter with in-order response routing
module periph_bus_arbiter #(
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [3:0]  m0_be,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,
    output logic        m0_err,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [3:0]  m1_be,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    output logic        m1_err,
    output logic        s_req,
    output logic        s_we,
    output logic [3:0]  s_be,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    input  logic        s_gnt,
    input  logic        s_rvalid,
    input  logic [31:0] s_rdata,
    input  logic        s_err
);
    localparam int PW = MAX_OUTSTANDING > 1 ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUTSTANDING);
    localparam logic [PW-1:0] PTR_LAST = PW'(MAX_OUTSTANDING - 1);
    localparam logic [1:0] IDLE = 2'd0, HOLD0 = 2'd1, HOLD1 = 2'd2;

    logic [1:0]                 state;
    logic                       last_winner;
    logic [MAX_OUTSTANDING-1:0] fifo;
    logic [PW-1:0]              wr_ptr, rd_ptr;
    logic [CW-1:0]              count;
    logic                       sel, push, pop, head;

    always_comb begin
        sel = state == HOLD1 ? 1'b1 :
              state == HOLD0 ? 1'b0 :
              (m0_req & m1_req) ? ~last_winner : m1_req;
        // a held selection is re-presented regardless of the outstanding count
        s_req = !rst && (state != IDLE || (count < CNT_MAX && (m0_req || m1_req)));
        s_we = s_req & (sel ? m1_we : m0_we);
        s_be = s_req ? (sel ? m1_be : m0_be) : '0;
        s_addr = s_req ? (sel ? m1_addr : m0_addr) : '0;
        s_wdata = s_req ? (sel ? m1_wdata : m0_wdata) : '0;
        push = s_req & s_gnt;
        m0_gnt = push & ~sel;
        m1_gnt = push & sel;
        pop = !rst && s_rvalid && count != '0;
        head = fifo[rd_ptr];
        m0_rvalid = pop & ~head;
        m1_rvalid = pop & head;
        m0_rdata = m0_rvalid ? s_rdata : '0;
        m1_rdata = m1_rvalid ? s_rdata : '0;
        m0_err = m0_rvalid & s_err;
        m1_err = m1_rvalid & s_err;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            last_winner <= 1'b1;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            state <= (s_req & ~s_gnt) ? (sel ? HOLD1 : HOLD0) : IDLE;
            if (push) begin
                fifo[wr_ptr] <= sel;
                wr_ptr <= wr_ptr == PTR_LAST ? '0 : wr_ptr + 1'b1;
                last_winner <= sel;
            end
            if (pop)
                rd_ptr <= rd_ptr == PTR_LAST ? '0 : rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end
endmodule

// File: tb/tb_periph_bus_arbiter.sv
// tb_periph_bus_arbiter: directed plus random stimulus against a queue-based arbiter model with a response scoreboard
module tb_periph_bus_arbiter;
    localparam int MAX = 2;

    logic        clk = 1'b0, rst;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [3:0]  m0_be, m1_be;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_req, s_we, s_gnt, s_rvalid, s_err;
    logic [3:0]  s_be;
    logic [31:0] s_addr, s_wdata, s_rdata;

    periph_bus_arbiter #(.MAX_OUTSTANDING(MAX)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_be(m0_be), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_be(m1_be), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .s_req(s_req), .s_we(s_we), .s_be(s_be), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_gnt(s_gnt), .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_err(s_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        id;
        logic [31:0] d;
        logic        e;
    } rsp_t;

    rsp_t sb[$];
    rsp_t mon_r;
    logic mq[$];
    int   hold = -1;
    logic lw = 1'b1;
    logic pg0, pg1;
    int   tests = 0, fails = 0;

    task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endtask

    // one bus cycle: drive slave inputs, predict outputs, check, then advance the model at the edge
    task automatic cycle(input logic g, input logic rv, input logic [31:0] rd, input logic e);
        logic sreq, sel;
        logic [68:0] bus;
        s_gnt = g; s_rvalid = rv; s_rdata = rd; s_err = e;
        sel = 1'b0;
        sreq = 1'b0;
        if (!rst) begin
            if (hold >= 0) begin
                sreq = 1'b1;
                sel = hold[0];
            end else if (mq.size() < MAX && (m0_req || m1_req)) begin
                sreq = 1'b1;
                sel = (m0_req && m1_req) ? ~lw : m1_req;
            end
            if (rv && mq.size() > 0) sb.push_back('{mq[0], rd, e});
        end
        bus = !sreq ? '0 : sel ? {m1_we, m1_be, m1_addr, m1_wdata} : {m0_we, m0_be, m0_addr, m0_wdata};
        pg0 = sreq && g && !sel;
        pg1 = sreq && g && sel;
        #1;
        chk("s_req", 128'(s_req), 128'(sreq));
        chk("s_bus", 128'({s_we, s_be, s_addr, s_wdata}), 128'(bus));
        chk("gnt", 128'({m0_gnt, m1_gnt}), 128'({pg0, pg1}));
        @(posedge clk);
        if (rst) begin
            hold = -1;
            lw = 1'b1;
            mq.delete();
        end else begin
            if (rv && mq.size() > 0) void'(mq.pop_front());
            if (sreq && g) begin
                mq.push_back(sel);
                lw = sel;
                hold = -1;
            end else if (sreq) hold = sel ? 1 : 0;
        end
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        #2;
        if (m0_rvalid || m1_rvalid) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL rsp_unexpected: got m0_rvalid=%b m1_rvalid=%b expected none", m0_rvalid, m1_rvalid);
            end else begin
                mon_r = sb.pop_front();
                chk("rsp", 128'({m0_rvalid, m0_rdata, m0_err, m1_rvalid, m1_rdata, m1_err}),
                    128'({!mon_r.id, mon_r.id ? 32'd0 : mon_r.d, !mon_r.id & mon_r.e,
                          mon_r.id, mon_r.id ? mon_r.d : 32'd0, mon_r.id & mon_r.e}));
            end
        end else begin
            if (sb.size() > 0) begin
                mon_r = sb.pop_front();
                tests++;
                fails++;
                $display("FAIL rsp_missing: got no rvalid expected master %0d data %h", mon_r.id, mon_r.d);
            end
            chk("rsp_idle", 128'({m0_rdata, m0_err, m1_rdata, m1_err}), 128'(0));
        end
    end

    task automatic new_m0();
        m0_req = $urandom_range(0, 3) != 0;
        m0_we = 1'($urandom); m0_be = 4'($urandom); m0_addr = $urandom; m0_wdata = $urandom;
    endtask

    task automatic new_m1();
        m1_req = $urandom_range(0, 3) != 0;
        m1_we = 1'($urandom); m1_be = 4'($urandom); m1_addr = $urandom; m1_wdata = $urandom;
    endtask

    task automatic reset_cycle();
        rst = 1'b1;
        cycle(1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        m0_req = 1'b1; m0_we = 1'b1; m0_be = 4'hF; m0_addr = 32'h1000_0000; m0_wdata = 32'hA5A5_A5A5;
        m1_req = 1'b1; m1_we = 1'b0; m1_be = 4'h3; m1_addr = 32'h2000_0000; m1_wdata = 32'h5A5A_5A5A;
        s_gnt = 1'b0; s_rvalid = 1'b0; s_rdata = '0; s_err = 1'b0;
        @(negedge clk);
        reset_cycle();
        reset_cycle();
        // single master back-to-back reads
        m1_req = 1'b0; m0_we = 1'b0; m0_addr = 32'h1000_0000;
        cycle(1'b1, 1'b0, 32'h0, 1'b0);
        m0_addr = 32'h1000_0004;
        cycle(1'b1, 1'b1, 32'h1111_0000, 1'b0);
        m0_req = 1'b0;
        cycle(1'b1, 1'b1, 32'h1111_0004, 1'b0);
        cycle(1'b0, 1'b0, 32'h0, 1'b0);
        // tie: m0 first after reset, then alternating
        reset_cycle();
        m0_req = 1'b1; m1_req = 1'b1;
        for (int i = 0; i < 5; i++) cycle(1'b1, i > 0, 32'h3000_0000 + i, 1'b0);
        m0_req = 1'b0; m1_req = 1'b0;
        cycle(1'b0, 1'b1, 32'h3000_00FF, 1'b0);
        // hold stability while m0 arrives
        m1_req = 1'b1; m1_addr = 32'h2000_0008;
        cycle(1'b0, 1'b0, 32'h0, 1'b0);
        m0_req = 1'b1;
        cycle(1'b0, 1'b0, 32'h0, 1'b0);
        cycle(1'b0, 1'b0, 32'h0, 1'b0);
        cycle(1'b1, 1'b0, 32'h0, 1'b0);
        m1_req = 1'b0;
        cycle(1'b1, 1'b0, 32'h0, 1'b0);
        m0_req = 1'b0;
        cycle(1'b0, 1'b1, 32'h4000_0001, 1'b0);
        cycle(1'b0, 1'b1, 32'h4000_0002, 1'b0);
        // outstanding limit
        m0_req = 1'b1;
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 32'h0, 1'b0);
        cycle(1'b1, 1'b1, 32'h5000_0001, 1'b0);
        cycle(1'b1, 1'b0, 32'h0, 1'b0);
        m0_req = 1'b0;
        cycle(1'b0, 1'b1, 32'h5000_0002, 1'b0);
        cycle(1'b0, 1'b1, 32'h5000_0003, 1'b0);
        // error and data routing
        m0_req = 1'b1;
        cycle(1'b1, 1'b0, 32'h0, 1'b0);
        m0_req = 1'b0; m1_req = 1'b1;
        cycle(1'b1, 1'b0, 32'h0, 1'b0);
        m1_req = 1'b0;
        cycle(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1);
        cycle(1'b0, 1'b1, 32'h1234_5678, 1'b0);
        // reset while in HOLD0 with one outstanding
        m0_req = 1'b1;
        cycle(1'b1, 1'b0, 32'h0, 1'b0);
        cycle(1'b0, 1'b0, 32'h0, 1'b0);
        rst = 1'b1;
        cycle(1'b0, 1'b0, 32'h0, 1'b0);
        rst = 1'b0; m0_req = 1'b0;
        cycle(1'b0, 1'b1, 32'h6666_6666, 1'b1);
        m0_req = 1'b1;
        cycle(1'b1, 1'b0, 32'h0, 1'b0);
        m0_req = 1'b0;
        cycle(1'b0, 1'b1, 32'h7777_7777, 1'b0);
        // random traffic
        new_m0();
        new_m1();
        for (int i = 0; i < 3000; i++) begin
            cycle(1'($urandom_range(0, 2) != 0), mq.size() > 0 && $urandom_range(0, 2) != 0, $urandom, 1'($urandom_range(0, 7) == 0));
            if (pg0 || !m0_req) new_m0();
            if (pg1 || !m1_req) new_m1();
        end
        while (hold >= 0) cycle(1'b1, 1'b0, 32'h0, 1'b0);
        m0_req = 1'b0; m1_req = 1'b0;
        for (int i = 0; i < 2 * MAX && mq.size() > 0; i++) cycle(1'b0, 1'b1, $urandom, 1'b0);
        cycle(1'b0, 1'b0, 32'h0, 1'b0);
        chk("drain", 128'(sb.size() + mq.size()), 128'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/periph_bus_arbiter.md
# periph_bus_arbiter

Two-master to one-slave arbiter for the peripheral data bus. The CPU data port (master 0) and the DMA engine (master 1) share the single req/gnt/rvalid slave port of the peripheral block. The arbiter selects masters round-robin and holds a selection stable until the slave grants it. An in-order outstanding-transaction FIFO routes each response back to the master that issued it. It sits between the interconnect and the peripheral block and adds no cycles of latency.

## Interface
Parameters:
- MAX_OUTSTANDING, default 2, maximum accepted-but-unanswered transfers; legal values are 1, 2 or 4.

Ports (N = 0, 1; one set per master):
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous and active-high.
- mN_req  input  1  master N request; held high until mN_gnt.
- mN_we  input  1  master N write enable.
- mN_be  input  4  master N byte enables.
- mN_addr  input  32  master N address.
- mN_wdata  input  32  master N write data.
- mN_gnt  output  1  master N request accepted this cycle.
- mN_rvalid  output  1  response for master N this cycle.
- mN_rdata  output  32  read data for master N; 0 when mN_rvalid=0.
- mN_err  output  1  error for master N; 0 when mN_rvalid=0.
- s_req  output  1  request to the peripheral block.
- s_we, s_be, s_addr, s_wdata  output  1/4/32/32  muxed from the selected master; 0 when s_req=0.
- s_gnt  input  1  peripheral grant.
- s_rvalid  input  1  peripheral response valid.
- s_rdata  input  32  peripheral read data.
- s_err  input  1  peripheral error.

## Operation
- State machine:
  - IDLE: no pending unaccepted request.
  - HOLD0 / HOLD1: master 0 / master 1 was presented to the slave last cycle and was not granted.
- Selection in IDLE:
  - Eligible when count < MAX_OUTSTANDING and m0_req or m1_req is high.
  - If only one master requests, it wins.
  - If both request, the master not equal to last_winner wins.
  - last_winner resets to 1, so master 0 wins the first tie.
- Selection in HOLDn: master n is presented unconditionally, even if count has since changed. Its s_* fields must not change while s_req=1 and s_gnt=0.
- Transitions:
  - s_req=1, s_gnt=0: go to HOLDsel.
  - s_req=1, s_gnt=1: go to IDLE; last_winner <= sel; push sel into the FIFO.
  - s_req=0: stay in IDLE.
- Grant routing: msel_gnt = s_gnt & s_req. The unselected master's gnt is 0.
- FIFO:
  - MAX_OUTSTANDING entries of 1 bit each, holding the master id, with a count of 0..MAX_OUTSTANDING.
  - On s_rvalid with count>0: pop the head; drive m[head]_rvalid, m[head]_rdata and m[head]_err from the slave. The other master sees rvalid=0, rdata=0, err=0.
  - Push and pop in the same cycle leave count unchanged. This is legal even at count==MAX.
  - At count==MAX no new request is issued in IDLE, even if s_rvalid is high that cycle (strict limit).
  - s_rvalid with count==0: the response is dropped and no master output is asserted. This is a protocol violation; the bench flags it.
- Pointers wrap modulo MAX_OUTSTANDING.

## Timing
- Reset:
  - While rst=1 (sampled at the edge): state <= IDLE, last_winner <= 1, FIFO pointers <= 0, count <= 0.
  - During the rst=1 cycle, all outputs are forced to 0: s_req, s_* fields, both gnt, both rvalid, rdata, err.
- Reset mid-transaction: the pending HOLD is abandoned and the FIFO is cleared. Responses arriving after reset are dropped (count==0).
- Combinational paths, zero added latency:
  - mN_req to s_req.
  - s_gnt to mN_gnt.
  - s_rvalid, s_rdata, s_err to mN_*.
- Response order equals grant order. A response may arrive in the cycle after the grant or later.
- Maximum throughput is one accepted transfer per cycle while count < MAX, or when the slave responds in the same cycle it grants the next transfer at count < MAX.

## Test plan
- Single master, slave always grants, rvalid one cycle later:
  - m0 reads 0x1000_0000, then 0x1000_0004, back-to-back.
  - Expect m0_gnt high in both cycles.
  - Expect m0_rvalid in the two following cycles with s_rdata passed through.
  - m1 outputs stay 0 throughout.
- Tie, round-robin:
  - m0_req and m1_req held high continuously; slave grants every cycle.
  - Grants alternate m0, m1, m0, m1, with m0 first after reset.
  - Responses route to masters in the same order.
- Hold stability:
  - Slave holds s_gnt=0 for 3 cycles while m1 (addr 0x2000_0008) is selected and m0 raises req in the second cycle.
  - s_addr stays 0x2000_0008 for all 3 cycles.
  - m1_gnt is asserted in the 4th cycle.
  - m0 is granted in the following cycle.
- Outstanding limit, MAX_OUTSTANDING=2:
  - Slave grants immediately but withholds rvalid; m0 issues 3 requests.
  - s_req drops after the 2nd grant.
  - The 3rd request is issued only in the cycle after the first s_rvalid.
- Error and data routing:
  - m0 then m1 granted; slave returns s_err=1 with rdata 0xDEAD_BEEF, then s_err=0 with rdata 0x1234_5678.
  - Expect m0_err=1 and m0_rdata=0xDEAD_BEEF.
  - Expect m1_rdata=0x1234_5678 and m1_err=0.
- Reset mid-operation:
  - Assert rst while in HOLD0 with 1 transfer outstanding.
  - All outputs are 0 in that cycle.
  - After reset, a late s_rvalid produces no mN_rvalid.
  - A subsequent m0 request is granted normally.
